link_failover_ctrl: RTL

Redundant-link failover controller sitting upstream of `post_switch`. It selects one of two GMII receive streams (link A / link B) and forwards it to `post_switch` up_* inputs. Switchover happens only at a frame boundary. Each completed switchover emits the one-cycle `trigger` that makes `post_switch` send its gratuitous-ARP burst. A holdoff timer prevents flapping.

---
 rtl/link_failover_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/link_failover_ctrl.sv
// Redundant GMII link failover: forwards link A or B downstream and switches only
// at a frame boundary, with abort framing on link loss and a post-switch holdoff.
module link_failover_ctrl #(
    parameter int IFG_MIN   = 12,
    parameter int HOLDOFF   = 1000,
    parameter bit PREFERRED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_dv,
    input  logic       a_er,
    input  logic [7:0] b_data,
    input  logic       b_dv,
    input  logic       b_er,
    input  logic       link_a_ok,
    input  logic       link_b_ok,
    input  logic       manual_req,
    output logic [7:0] down_data,
    output logic       down_dv,
    output logic       down_er,
    output logic       sel,
    output logic       trigger,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_CUT     = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [7:0]  IFG_LIM   = 8'(IFG_MIN);
    localparam logic [19:0] HOLD_LOAD = 20'(HOLDOFF);

    state_t      state;
    logic [7:0]  idle_cnt;
    logic [19:0] hold_cnt;
    logic        man_latch;
    logic        abort_q;

    logic        cur_ok;
    logic        oth_ok;
    logic        oth_dv;
    logic [7:0]  in_data;
    logic        in_dv;
    logic        in_er;
    logic [7:0]  idle_next;
    logic        want_switch;
    logic        cut_go;
    logic        abort;
    logic        man_clr;

    always_comb begin
        cur_ok  = sel ? link_b_ok : link_a_ok;
        oth_ok  = sel ? link_a_ok : link_b_ok;
        oth_dv  = sel ? a_dv : b_dv;
        in_data = sel ? b_data : a_data;
        in_dv   = sel ? b_dv : a_dv;
        in_er   = sel ? b_er : a_er;

        // idle_next already includes the cycle now on down_*, so the cut decision
        // fires on the edge that completes IFG_MIN idle output cycles.
        if (down_dv || down_er) begin
            idle_next = 8'd0;
        end else if (idle_cnt == 8'hFF) begin
            idle_next = 8'hFF;
        end else begin
            idle_next = idle_cnt + 8'd1;
        end

        want_switch = oth_ok && (!cur_ok || man_latch);
        cut_go      = (state == ST_PENDING) && want_switch &&
                      (idle_next >= IFG_LIM) && !oth_dv;
        abort       = !cur_ok && down_dv && !abort_q;
        man_clr     = cut_go ||
                      (!oth_ok && ((state == ST_ACTIVE) || (state == ST_PENDING)));
    end

    // Datapath: one-cycle forwarding; the decision edge is forced idle so no stray
    // byte of the old link leaks out just before the switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_data <= 8'd0;
            down_dv   <= 1'b0;
            down_er   <= 1'b0;
            abort_q   <= 1'b0;
            idle_cnt  <= 8'd0;
        end else begin
            abort_q  <= abort;
            idle_cnt <= idle_next;
            if (!cur_ok || cut_go) begin
                down_data <= 8'd0;
                down_dv   <= abort;
                down_er   <= abort;
            end else begin
                down_data <= in_data;
                down_dv   <= in_dv;
                down_er   <= in_er;
            end
        end
    end

    // Control FSM; sel/trigger/holdoff load all happen on the PENDING->CUT edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACTIVE;
            sel       <= PREFERRED;
            trigger   <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= 20'd0;
            man_latch <= 1'b0;
        end else begin
            trigger   <= 1'b0;
            busy      <= (state != ST_ACTIVE);
            man_latch <= manual_req || (man_latch && !man_clr);
            case (state)
                ST_ACTIVE: begin
                    if (want_switch) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!want_switch) begin
                        state <= ST_ACTIVE;
                    end else if (cut_go) begin
                        state    <= ST_CUT;
                        sel      <= ~sel;
                        trigger  <= 1'b1;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                ST_CUT: begin
                    state <= ST_HOLDOFF;
                    if (hold_cnt != 20'd0) begin
                        hold_cnt <= hold_cnt - 20'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == 20'd0) begin
                        state <= ST_ACTIVE;
                    end else begin
                        hold_cnt <= hold_cnt - 20'd1;
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

endmodule
